regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: late-unit pending-write queue depth (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 4: cycles a queued late write waits before it is force-granted.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted low clears all state immediately.
REQ-005 wb_req_valid  in  1  WB stage presents a register write.
REQ-006 wb_req_address  in  5  WB destination register.
REQ-007 wb_req_data  in  32  WB write data.
REQ-008 wb_req_ready  out  1  WB write accepted this cycle; drives WB ready_go.
REQ-009 lu_req_valid  in  1  long-latency unit (divider / late load) presents a write.
REQ-010 lu_req_address  in  5  late-unit destination register.
REQ-011 lu_req_data  in  32  late-unit write data.
REQ-012 lu_req_ready  out  1  late-unit write enqueued this cycle.
REQ-013 rf_write_enabled  out  1  register-file write strobe.
REQ-014 rf_write_address  out  5  register-file write address.
REQ-015 rf_write_data  out  32  register-file write data.
REQ-016 busy_registers  out  32  bit n set while any queued entry targets register n; ID stalls on hit.

Function
REQ-017 Late writes SHALL always pass through the FIFO; lu_req_ready = FIFO not full (no same-cycle enqueue on full, even if dequeuing).
REQ-018 Writes to address 0 SHALL be handshaken normally but never enqueued nor driven as rf_write_enabled.
REQ-019 Each cycle exactly one source SHALL be granted: WB if wb_req_valid and not held, else FIFO head if non-empty, else none.
REQ-020 WB SHALL be held (wb_req_ready=0, head granted) when wb_req_address matches any queued entry's address (WAW ordering).
REQ-021 wb_req_ready SHALL be 1 when wb_req_valid is 0 and not held, so an idle WB never blocks.
REQ-022 Granted write SHALL be registered: rf_write_* update at the edge ending the grant cycle (1-cycle latency), rf_write_enabled=0 in cycles after no grant.
REQ-023 Enqueue at edge N SHALL make the entry eligible for grant in cycle N+1 at the earliest.
REQ-024 Simultaneous enqueue and head dequeue on non-full FIFO SHALL both occur; occupancy unchanged.
REQ-025 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, with full/empty from a separate occupancy count.
REQ-026 busy_registers SHALL be combinational from FIFO contents; bit 0 always 0.

Reset
REQ-027 On reset low: FIFO empty, starvation counter 0, rf_write_enabled=0, rf_write_address=0, rf_write_data=0, busy_registers=0.
REQ-028 During reset wb_req_ready=0 and lu_req_ready=0; queued writes in flight at reset SHALL be discarded.

Configuration
REQ-029 Macro REGFILE_ARB_STARVE_GUARD_EN defined: counter increments each cycle FIFO non-empty and head not granted, clears on head grant or empty, saturates at STARVE_LIMIT; at STARVE_LIMIT wb_req_ready=0 and head is granted.
REQ-030 Macro undefined: no counter; strict WB priority except REQ-020.

Structure
REQ-031 Shared package regfile_arbiter_params SHALL hold RFWriteRequest struct (valid, address, data), FIFO_DEPTH and STARVE_LIMIT defaults; CpuData reused from cpu_core_params.
REQ-032 Queue SHALL be sub-module regfile_arbiter_fifo exposing head, push/pop, full/empty and per-entry address array.

Verification
REQ-033 LU writes r5=0x11 with WB idle -> enqueue edge N, rf_write r5=0x11 visible after edge N+1, busy bit5 set one cycle.
REQ-034 WB r3=0xA and LU r7=0xB same cycle, queue empty -> r3 written first, r7 next cycle.
REQ-035 Queue holds r9; WB writes r9 -> wb_req_ready=0 until r9 from LU written, then WB r9 written next.
REQ-036 Guard enabled, STARVE_LIMIT=4, WB valid every cycle, one queued entry -> head written on 5th cycle, wb_req_ready=0 that cycle.
REQ-037 Fill 2 entries, LU still valid -> lu_req_ready=0; pop -> ready=1 next cycle; LU r0 write -> accepted, no rf write.
REQ-038 Reset low mid-drain with 2 entries queued -> outputs zero immediately, no further writes after release.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// ============================================================================
//  Packages : cpu_core_params, regfile_arbiter_params
//  Brief    : Shared types and defaults for the register-file write arbiter.
//             cpu_core_params carries the core data word type; the arbiter
//             package builds its write-request record on top of it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_core_params;
  typedef logic [31:0] CpuData;
endpackage

package regfile_arbiter_params;
  import cpu_core_params::*;

  localparam int DEFAULT_FIFO_DEPTH   = 2;
  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int REG_ADDR_W           = 5;
  localparam int NUM_REGS             = 32;

  typedef logic [REG_ADDR_W-1:0] RegAddr;

  typedef struct packed {
    logic   valid;
    RegAddr address;
    CpuData data;
  } RFWriteRequest;

  // One-hot decode of a register index into a busy-mask contribution.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input RegAddr addr);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction
endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_fifo.sv
// ============================================================================
//  Module   : regfile_arbiter_fifo
//  Brief    : Pending-write queue for the long-latency unit. Pointers wrap
//             modulo DEPTH; full/empty come from a separate occupancy count.
//             Every slot's valid bit and address are exported so the parent
//             can build the busy-register scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_arbiter_fifo
  import cpu_core_params::*;
  import regfile_arbiter_params::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  push_i,
  input  logic [REG_ADDR_W-1:0]                 push_addr_i,
  input  logic [31:0]                           push_data_i,
  input  logic                                  pop_i,
  output logic [REG_ADDR_W-1:0]                 head_addr_o,
  output logic [31:0]                           head_data_o,
  output logic                                  full_o,
  output logic                                  empty_o,
  output logic [DEPTH-1:0]                      entry_valid_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_addr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  RFWriteRequest    mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  // A push on a full queue is refused even if a pop happens the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage and pointers; reset discards every pending write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_pop)  mem_q[rd_ptr_q].valid <= 1'b0;
      if (do_push) mem_q[wr_ptr_q] <= '{valid: 1'b1, address: push_addr_i, data: push_data_i};
    end
  end

  assign head_addr_o = mem_q[rd_ptr_q].address;
  assign head_data_o = mem_q[rd_ptr_q].data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry_out
    assign entry_valid_o[g] = mem_q[g].valid;
    assign entry_addr_o[g]  = mem_q[g].address;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
//  Module   : regfile_write_arbiter
//  Brief    : Arbitrates the single register-file write port between the WB
//             stage and a long-latency unit. Late writes always go through a
//             small queue; WB wins unless it would overtake a queued write to
//             the same register. The granted write is registered onto
//             rf_write_*. busy_registers flags registers with queued writes.
//  Options  : REGFILE_ARB_STARVE_GUARD_EN - when defined, a starvation counter
//             force-grants the queue head after STARVE_LIMIT waiting cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
  import cpu_core_params::*;
  import regfile_arbiter_params::*;
#(
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_req_valid,
  input  logic [REG_ADDR_W-1:0] wb_req_address,
  input  logic [31:0]           wb_req_data,
  output logic                  wb_req_ready,
  input  logic                  lu_req_valid,
  input  logic [REG_ADDR_W-1:0] lu_req_address,
  input  logic [31:0]           lu_req_data,
  output logic                  lu_req_ready,
  output logic                  rf_write_enabled,
  output logic [REG_ADDR_W-1:0] rf_write_address,
  output logic [31:0]           rf_write_data,
  output logic [NUM_REGS-1:0]   busy_registers
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
    $error("regfile_write_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic                                 fifo_full;
  logic                                 fifo_empty;
  logic [REG_ADDR_W-1:0]                head_addr;
  CpuData                               head_data;
  logic [FIFO_DEPTH-1:0]                entry_valid;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
  logic [NUM_REGS-1:0]                  busy_mask;
  logic                                 wb_hit;
  logic                                 starve_force;
  logic                                 grant_wb;
  logic                                 grant_head;
  logic                                 lu_push;
  RFWriteRequest                        rf_q, rf_d;

  regfile_arbiter_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (clock),
    .rst_ni        (reset),
    .push_i        (lu_push),
    .push_addr_i   (lu_req_address),
    .push_data_i   (lu_req_data),
    .pop_i         (grant_head),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_addr_o  (entry_addr)
  );

  // Busy scoreboard: union of the targets of every occupied queue slot.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) busy_mask = busy_mask | reg_onehot(entry_addr[i]);
    end
    busy_mask[0] = 1'b0;
  end

  assign busy_registers = busy_mask;
  // WB must not overtake a queued write to the same register (WAW order).
  assign wb_hit = wb_req_valid && busy_mask[wb_req_address];

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;

  // Count cycles the head waits; clear once it drains or the queue empties.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || grant_head) begin
      starve_d = '0;
    end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  assign starve_force = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
  assign starve_force = 1'b0;
`endif

  // Ready is gated by reset so nothing is handshaken while held in reset.
  assign wb_req_ready = reset && !wb_hit && !starve_force;
  assign lu_req_ready = reset && !fifo_full;
  assign grant_wb     = wb_req_valid && wb_req_ready;
  assign grant_head   = reset && !grant_wb && !fifo_empty;
  // Writes to r0 complete the handshake but never occupy a queue slot.
  assign lu_push      = lu_req_valid && lu_req_ready && (lu_req_address != '0);

  // Select the granted write; r0 writes are accepted but never strobed.
  always_comb begin
    rf_d       = rf_q;
    rf_d.valid = 1'b0;
    if (grant_wb) begin
      rf_d.valid   = (wb_req_address != '0);
      rf_d.address = wb_req_address;
      rf_d.data    = wb_req_data;
    end else if (grant_head) begin
      rf_d.valid   = 1'b1;
      rf_d.address = head_addr;
      rf_d.data    = head_data;
    end
  end

  // Register-file write port register (one cycle after the grant).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rf_q <= '0;
    else        rf_q <= rf_d;
  end

  assign rf_write_enabled = rf_q.valid;
  assign rf_write_address = rf_q.address;
  assign rf_write_data    = rf_q.data;

endmodule

`default_nettype wire
